trapezoid_raster_gen2: RTL and testbench
========================================

// Module: trapezoid_raster_gen2
// PURPOSE
//  Parametrised second-generation trapezoid rendering engine. Loads four vertices:
//   (xul,yu), (xur,yu), (xdl,yd), (xdr,yd).
//  Emits every integer pixel inside the trapezoid, one per accepted handshake.
//  Adds over gen1: coordinate-width parameter, scan-direction parameter, po/po_ready
//  backpressure and an input-error flag. Sits between the vertex source and the frame writer.
// PARAMETERS
//  CW        8  coordinate width in bits (xi/yi/xo/yo)
//  TOP_DOWN  0  0: rows emitted yd->yu ascending; 1: rows emitted yu->yd descending
// PORTS
//  clk       in   1   clock, all logic on rising edge
//  reset     in   1   synchronous, active-low reset
//  nt        in   1   new trapezoid; high with vertex 0 only
//  xi        in   CW  vertex x, valid on 4 consecutive cycles starting at nt
//  yi        in   CW  vertex y, same timing as xi
//  po_ready  in   1   downstream accepts pixel when po&&po_ready
//  busy      out  1   engine occupied; nt ignored while high
//  po        out  1   xo/yo valid
//  xo        out  CW  pixel x
//  yo        out  CW  pixel y
//  err       out  1   one-cycle pulse: rejected trapezoid (yd>yu)
// BEHAVIOUR
//  Reset: busy=0, po=0, xo=0, yo=0, err=0, pix_cnt=0, FSM=IDLE; applies mid-operation, current shape dropped.
//  Load: cycle 0 (nt=1) vertex UL, then UR, DL, DR on the next 3 cycles; busy=1 from the cycle after nt.
//  FSM: IDLE->LOAD(3 cyc)->CHECK->DIV_L->DIV_R->ROW->EMIT->(ROW|DONE)->IDLE.
//  CHECK: yd>yu -> err=1 for 1 cycle, DONE, no pixels. yd==yu -> skip DIV_*; single row, span xdl..xdr.
//  Edges: dy=yu-yd; dxL=xul-xdl, dxR=xur-xdr, signed CW+1 bits.
//   DIV_*: floor division, q=floor(dx/dy), r in [0,dy); CW+1 cycles each.
//  Row DDA: per-edge integer part a and remainder b, init (xdl|xdr, 0) at yd; each row step a+=q, b+=r, if b>=dy {b-=dy; a+=1}.
//   TOP_DOWN=1 starts at yu with (xul|xur, 0) and steps with -q/-r, borrow symmetric.
//  Span: xl=aL+(bL!=0) (ceil), xr=aR (floor). xl>xr -> row emits nothing (ROW->next row, 1 cycle).
//  EMIT: x from xl to xr ascending, yo=current row. po held with xo/yo stable until po_ready.
//   One pixel per cycle when po_ready stays high.
//  After the last pixel handshake: DONE (po=0), busy=0 next cycle.
//   busy then stays low >=1 cycle before a new nt is accepted.
//  nt while busy: ignored. xi/yi outside load cycles: don't-care (may be Z).
//  No wrap: all intermediates CW+1 bits, valid pixels always within 0..2^CW-1.
// CONFIGURATION
//  TRAP_PIXCNT_EN defined: adds output pix_cnt [2*CW:0].
//   Cleared at nt; +1 per pixel handshake; holds final count until next nt.
//  TRAP_PIXCNT_EN undefined: port and counter absent; no other change.
// STRUCTURE
//  Package trapezoid_pkg: FSM state enum, coord_t (CW), edge_t (CW+1 signed), localparam DIV_CYC=CW+1.
//  Sub-module trap_edge_div: sequential restoring signed floor divider.
//   Interface: start/dx/dy in; done/q/r out. Instantiated once, reused for L then R.
// TESTING (CW=8, po_ready=1 unless noted)
//  1 rect UL(2,5) UR(4,5) DL(2,3) DR(4,3) -> 9 pixels (2,3)(3,3)(4,3)(2,4)..(4,5), busy falls after last.
//  2 flat UL(1,7) UR(9,7) DL(3,7) DR(5,7) -> (3,7)(4,7)(5,7) only.
//  3 slant UL(0,4) UR(8,4) DL(2,0) DR(4,0) -> rows 2..4, 2..5, 1..6, 1..7, 0..8; 29 pixels.
//  4 test 1 with po_ready pattern 1,0,0,1 repeating -> same 9 pixels, xo/yo stable while stalled.
//  5 UL(1,2) UR(3,2) DL(1,6) DR(3,6) -> err pulse 1 cycle, no po, busy low after.
//  6 reset low during EMIT of test 3 -> all outputs 0 next edge; rerun test 1 -> exact test-1 output.

Source files
------------

// File: rtl/trapezoid_pkg.sv
// Shared types for the trapezoid raster engine.
// Holds the FSM state encoding, the default-width coordinate and edge types,
// and the divider cycle count. The default build has TRAP_PIXCNT_EN undefined;
// defining it adds the pix_cnt output to the interface and the top.
package trapezoid_pkg;

    localparam int CW_DEF  = 8;
    localparam int DIV_CYC = CW_DEF + 1;

    typedef logic [CW_DEF-1:0]      coord_t;
    typedef logic signed [CW_DEF:0] edge_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_DIV_L = 3'd3,
        S_DIV_R = 3'd4,
        S_ROW   = 3'd5,
        S_EMIT  = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    // One iteration per quotient bit; quotients are cw+1 bits wide.
    function automatic int div_cycles(input int cw);
        return cw + 1;
    endfunction

endpackage

// File: rtl/trapezoid_raster_gen2_if.sv
// Handshake bundle between vertex source / frame writer and the raster engine.
// master: the environment (drives nt, xi, yi, po_ready).
// slave : the engine (drives busy, po, xo, yo, err and, with TRAP_PIXCNT_EN, pix_cnt).
interface trapezoid_raster_gen2_if #(parameter int CW = 8);

    logic          nt;
    logic [CW-1:0] xi;
    logic [CW-1:0] yi;
    logic          po_ready;
    logic          busy;
    logic          po;
    logic [CW-1:0] xo;
    logic [CW-1:0] yo;
    logic          err;
`ifdef TRAP_PIXCNT_EN
    logic [2*CW:0] pix_cnt;

    modport master (output nt, xi, yi, po_ready, input busy, po, xo, yo, err, pix_cnt);
    modport slave  (input nt, xi, yi, po_ready, output busy, po, xo, yo, err, pix_cnt);
`else
    modport master (output nt, xi, yi, po_ready, input busy, po, xo, yo, err);
    modport slave  (input nt, xi, yi, po_ready, output busy, po, xo, yo, err);
`endif

endinterface

// File: rtl/trap_edge_div.sv
// Sequential restoring signed floor divider for one trapezoid edge.
// Ports: clk, reset (sync, active-low); start loads dx/dy; done pulses one
// cycle after CW+1 iterations, when q = floor(dx/dy) and r in [0,dy) are valid
// (q/r hold until the next start). dy must be positive.
module trap_edge_div
    import trapezoid_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic signed [CW:0]  dx,
    input  logic signed [CW:0]  dy,
    output logic                done,
    output logic signed [CW:0]  q,
    output logic signed [CW:0]  r
);

    localparam int N    = div_cycles(CW);
    localparam int CNTW = $clog2(N) + 1;

    logic            r_run;
    logic            r_done;
    logic            r_neg;
    logic [CNTW-1:0] r_cnt;
    logic [N-1:0]    r_quo;
    logic [N-1:0]    r_rem;
    logic [N-1:0]    r_dy;

    logic [N:0]      w_shift;
    logic            w_ge;
    logic [N-1:0]    w_rem_nxt;
    logic [N-1:0]    w_quo_nxt;

    // One restoring step on the magnitude, plus floor fix-up for negative dx.
    always_comb begin
        w_shift   = {r_rem, r_quo[N-1]};
        w_ge      = (w_shift >= {1'b0, r_dy});
        w_quo_nxt = {r_quo[N-2:0], w_ge};
        if (w_ge) begin
            w_rem_nxt = N'(w_shift - {1'b0, r_dy});
        end else begin
            w_rem_nxt = w_shift[N-1:0];
        end
        // Truncated magnitude result becomes floor: a non-zero remainder on a
        // negative dividend pulls q down by one and reflects r into [0,dy).
        if (!r_neg) begin
            q = $signed(r_quo);
            r = $signed(r_rem);
        end else if (r_rem == {N{1'b0}}) begin
            q = -$signed(r_quo);
            r = {N{1'b0}};
        end else begin
            q = -$signed(r_quo) - N'(1);
            r = $signed(r_dy - r_rem);
        end
    end

    // Iteration counter and quotient/remainder registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_run  <= 1'b0;
            r_done <= 1'b0;
            r_neg  <= 1'b0;
            r_cnt  <= {CNTW{1'b0}};
            r_quo  <= {N{1'b0}};
            r_rem  <= {N{1'b0}};
            r_dy   <= {N{1'b0}};
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_run <= 1'b1;
                r_neg <= dx[CW];
                r_cnt <= {CNTW{1'b0}};
                r_quo <= dx[CW] ? $unsigned(-dx) : $unsigned(dx);
                r_rem <= {N{1'b0}};
                r_dy  <= $unsigned(dy);
            end else if (r_run) begin
                r_quo <= w_quo_nxt;
                r_rem <= w_rem_nxt;
                if (r_cnt == CNTW'(N - 1)) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CNTW'(1);
                end
            end else begin
                r_run <= 1'b0;
            end
        end
    end

    assign done = r_done;

endmodule

// File: rtl/trapezoid_raster_gen2.sv
// Second-generation trapezoid raster engine.
// Loads UL, UR, DL, DR over four cycles starting at nt, divides both edges once,
// then walks rows with an integer DDA and emits every pixel of each row span
// over a po/po_ready handshake. yd>yu is rejected with a one-cycle err pulse.
// Ports: clk, reset (sync, active-low), bus (slave modport: nt, xi, yi,
// po_ready in; busy, po, xo, yo, err out). TOP_DOWN selects row order.
// Optional macro TRAP_PIXCNT_EN adds the pix_cnt pixel counter output.
module trapezoid_raster_gen2
    import trapezoid_pkg::*;
#(
    parameter int CW       = 8,
    parameter int TOP_DOWN = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    trapezoid_raster_gen2_if.slave  bus
);

    typedef logic signed [CW:0]   sedge_t;
    typedef logic signed [CW+1:0] acc_t;
    typedef struct packed {
        acc_t a;
        acc_t b;
    } dda_t;

    state_t        r_state;
    logic [1:0]    r_ld_cnt;
    logic [CW-1:0] r_xul, r_xur, r_xdl, r_xdr, r_yu, r_yd;
    logic [CW-1:0] r_row, r_x, r_xr, r_xo, r_yo;
    sedge_t        r_dy, r_qL, r_rL, r_qR, r_rR, r_div_dx;
    dda_t          r_eL, r_eR;
    logic          r_div_start, r_busy, r_po, r_err;

    logic          w_div_done;
    sedge_t        w_div_q, w_div_r;
    dda_t          w_eL_nxt, w_eR_nxt;
    acc_t          w_xl;
    logic          w_empty, w_last_row, w_hs;
    logic [CW-1:0] w_row_nxt;

    // Advance one edge by one row; the remainder stays in [0,dy) by carry/borrow.
    function automatic dda_t dda_step(dda_t cur, sedge_t qs, sedge_t rs, sedge_t dys);
        dda_t nxt;
        nxt = cur;
        if (TOP_DOWN != 0) begin
            nxt.a = cur.a - acc_t'(qs);
            nxt.b = cur.b - acc_t'(rs);
            if (nxt.b < acc_t'(0)) begin
                nxt.b = nxt.b + acc_t'(dys);
                nxt.a = nxt.a - acc_t'(1);
            end else begin
                nxt.a = nxt.a;
            end
        end else begin
            nxt.a = cur.a + acc_t'(qs);
            nxt.b = cur.b + acc_t'(rs);
            if (nxt.b >= acc_t'(dys)) begin
                nxt.b = nxt.b - acc_t'(dys);
                nxt.a = nxt.a + acc_t'(1);
            end else begin
                nxt.a = nxt.a;
            end
        end
        return nxt;
    endfunction

    trap_edge_div #(.CW(CW)) u_div (
        .clk   (clk),
        .reset (reset),
        .start (r_div_start),
        .dx    (r_div_dx),
        .dy    (r_dy),
        .done  (w_div_done),
        .q     (w_div_q),
        .r     (w_div_r)
    );

    // Next-row edge state, current span and handshake decode.
    always_comb begin
        w_eL_nxt   = dda_step(r_eL, r_qL, r_rL, r_dy);
        w_eR_nxt   = dda_step(r_eR, r_qR, r_rR, r_dy);
        // Left bound rounds up, right bound rounds down.
        w_xl       = r_eL.a + ((r_eL.b != acc_t'(0)) ? acc_t'(1) : acc_t'(0));
        w_empty    = (w_xl > r_eR.a);
        w_last_row = (r_row == ((TOP_DOWN != 0) ? r_yd : r_yu));
        w_row_nxt  = (TOP_DOWN != 0) ? (r_row - CW'(1)) : (r_row + CW'(1));
        w_hs       = r_po && bus.po_ready;
    end

    // Main control FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_ld_cnt    <= 2'd0;
            {r_xul, r_xur, r_xdl, r_xdr, r_yu, r_yd} <= {(6*CW){1'b0}};
            {r_row, r_x, r_xr, r_xo, r_yo}           <= {(5*CW){1'b0}};
            {r_dy, r_qL, r_rL, r_qR, r_rR, r_div_dx} <= {(6*(CW+1)){1'b0}};
            r_eL        <= {(2*(CW+2)){1'b0}};
            r_eR        <= {(2*(CW+2)){1'b0}};
            r_div_start <= 1'b0;
            r_busy      <= 1'b0;
            r_po        <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_div_start <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.nt) begin
                        r_xul    <= bus.xi;
                        r_yu     <= bus.yi;
                        r_ld_cnt <= 2'd0;
                        r_busy   <= 1'b1;
                        r_state  <= S_LOAD;
                    end else begin
                        r_busy   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    case (r_ld_cnt)
                        2'd0:    r_xur <= bus.xi;
                        2'd1:    begin r_xdl <= bus.xi; r_yd <= bus.yi; end
                        default: r_xdr <= bus.xi;
                    endcase
                    r_ld_cnt <= r_ld_cnt + 2'd1;
                    if (r_ld_cnt == 2'd2) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_state <= S_LOAD;
                    end
                end
                S_CHECK: begin
                    r_dy <= $signed({1'b0, r_yu}) - $signed({1'b0, r_yd});
                    if (r_yd > r_yu) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_yd == r_yu) begin
                        // Flat shape: one row spanning the bottom pair, no division.
                        r_eL    <= '{a: acc_t'({2'b00, r_xdl}), b: acc_t'(0)};
                        r_eR    <= '{a: acc_t'({2'b00, r_xdr}), b: acc_t'(0)};
                        r_row   <= r_yd;
                        r_state <= S_ROW;
                    end else begin
                        r_div_dx    <= $signed({1'b0, r_xul}) - $signed({1'b0, r_xdl});
                        r_div_start <= 1'b1;
                        r_state     <= S_DIV_L;
                    end
                end
                S_DIV_L: begin
                    if (w_div_done) begin
                        r_qL        <= w_div_q;
                        r_rL        <= w_div_r;
                        r_div_dx    <= $signed({1'b0, r_xur}) - $signed({1'b0, r_xdr});
                        r_div_start <= 1'b1;
                        r_state     <= S_DIV_R;
                    end else begin
                        r_state     <= S_DIV_L;
                    end
                end
                S_DIV_R: begin
                    if (w_div_done) begin
                        r_qR <= w_div_q;
                        r_rR <= w_div_r;
                        if (TOP_DOWN != 0) begin
                            r_eL  <= '{a: acc_t'({2'b00, r_xul}), b: acc_t'(0)};
                            r_eR  <= '{a: acc_t'({2'b00, r_xur}), b: acc_t'(0)};
                            r_row <= r_yu;
                        end else begin
                            r_eL  <= '{a: acc_t'({2'b00, r_xdl}), b: acc_t'(0)};
                            r_eR  <= '{a: acc_t'({2'b00, r_xdr}), b: acc_t'(0)};
                            r_row <= r_yd;
                        end
                        r_state <= S_ROW;
                    end else begin
                        r_state <= S_DIV_R;
                    end
                end
                S_ROW: begin
                    if (w_empty) begin
                        if (w_last_row) begin
                            r_state <= S_DONE;
                        end else begin
                            r_eL    <= w_eL_nxt;
                            r_eR    <= w_eR_nxt;
                            r_row   <= w_row_nxt;
                            r_state <= S_ROW;
                        end
                    end else begin
                        r_x     <= w_xl[CW-1:0];
                        r_xr    <= r_eR.a[CW-1:0];
                        r_xo    <= w_xl[CW-1:0];
                        r_yo    <= r_row;
                        r_po    <= 1'b1;
                        r_state <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (w_hs) begin
                        if (r_x == r_xr) begin
                            r_po <= 1'b0;
                            if (w_last_row) begin
                                r_state <= S_DONE;
                            end else begin
                                r_eL    <= w_eL_nxt;
                                r_eR    <= w_eR_nxt;
                                r_row   <= w_row_nxt;
                                r_state <= S_ROW;
                            end
                        end else begin
                            r_x  <= r_x + CW'(1);
                            r_xo <= r_x + CW'(1);
                        end
                    end else begin
                        r_state <= S_EMIT;
                    end
                end
                S_DONE: begin
                    r_po    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_po    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.po   = r_po;
    assign bus.xo   = r_xo;
    assign bus.yo   = r_yo;
    assign bus.err  = r_err;

`ifdef TRAP_PIXCNT_EN
    logic [2*CW:0] r_pix_cnt;

    // Pixel counter: cleared on an accepted nt, counts handshakes, holds after.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pix_cnt <= {(2*CW+1){1'b0}};
        end else if ((r_state == S_IDLE) && bus.nt) begin
            r_pix_cnt <= {(2*CW+1){1'b0}};
        end else if (w_hs) begin
            r_pix_cnt <= r_pix_cnt + (2*CW+1)'(1);
        end else begin
            r_pix_cnt <= r_pix_cnt;
        end
    end

    assign bus.pix_cnt = r_pix_cnt;
`endif

endmodule

// File: tb/tb_trapezoid_raster_gen2.sv
// Self-checking bench for trapezoid_raster_gen2 (CW=8, TOP_DOWN=0).
// Expected pixels come from an exact rational edge model and are queued per
// shape; DUT handshakes pop and compare them.
module tb_trapezoid_raster_gen2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    trapezoid_raster_gen2_if #(.CW(8)) bus();

    trapezoid_raster_gen2 #(.CW(8), .TOP_DOWN(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string name;
        int xul, yu, xur, xdl, yd, xdr;
        int rdy_mode;     // 0: always ready, 1: pattern 1,0,0,1
        int abort_after;  // >0: reset after this many pixels
        int exp_pix;
        int exp_err;
    } vec_t;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
    } pix_t;

    vec_t vecs[7];
    pix_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int fdiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int cdiv(input int a, input int b);
        return -fdiv(-a, b);
    endfunction

    task automatic push_pix(input int x, input int y);
        pix_t p;
        p.x = 8'(x);
        p.y = 8'(y);
        exp_q.push_back(p);
    endtask

    // Exact model: left x on row y is xdl + dxL*(y-yd)/dy, rounded up; right rounded down.
    task automatic push_expected(input vec_t v);
        int dy, xl, xr;
        if (v.yd > v.yu) return;
        if (v.yd == v.yu) begin
            for (int x = v.xdl; x <= v.xdr; x++) push_pix(x, v.yd);
            return;
        end
        dy = v.yu - v.yd;
        for (int y = v.yd; y <= v.yu; y++) begin
            xl = cdiv(v.xdl * dy + (v.xul - v.xdl) * (y - v.yd), dy);
            xr = fdiv(v.xdr * dy + (v.xur - v.xdr) * (y - v.yd), dy);
            for (int x = xl; x <= xr; x++) push_pix(x, y);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   cyc, seen, errc;
        logic rdy, prev_stall;
        logic [7:0] pxo, pyo;
        pix_t p;

        exp_q.delete();
        push_expected(v);

        @(negedge clk);
        cyc = 0;
        while (bus.busy && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 200) check({v.name, "_idle_timeout"}, 1, 0);

        bus.po_ready = 1'b1;
        bus.nt = 1'b1; bus.xi = 8'(v.xul); bus.yi = 8'(v.yu);
        @(negedge clk);
        bus.nt = 1'b0;
        check({v.name, "_busy_after_nt"}, int'(bus.busy), 1);
        bus.xi = 8'(v.xur); bus.yi = 8'(v.yu);
        @(negedge clk);
        bus.xi = 8'(v.xdl); bus.yi = 8'(v.yd);
        @(negedge clk);
        bus.xi = 8'(v.xdr); bus.yi = 8'(v.yd);
        @(negedge clk);
        bus.xi = 8'hA5; bus.yi = 8'h5A;

        seen = 0; errc = 0; prev_stall = 1'b0; pxo = 8'd0; pyo = 8'd0; cyc = 0;
        while (cyc < 3000) begin
            rdy = (v.rdy_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            bus.po_ready = rdy;
            if (prev_stall) begin
                check({v.name, "_stall_po"}, int'(bus.po), 1);
                check({v.name, "_stall_xo"}, int'(bus.xo), int'(pxo));
                check({v.name, "_stall_yo"}, int'(bus.yo), int'(pyo));
            end
            if (bus.err) errc++;
            if (bus.po && rdy) begin
                if (exp_q.size() == 0) begin
                    check({v.name, "_extra_pixel"}, int'({bus.xo, bus.yo}), -1);
                end else begin
                    p = exp_q.pop_front();
                    check({v.name, "_pix_x"}, int'(bus.xo), int'(p.x));
                    check({v.name, "_pix_y"}, int'(bus.yo), int'(p.y));
                end
                seen++;
            end
            prev_stall = bus.po && !rdy;
            pxo = bus.xo;
            pyo = bus.yo;
            if ((v.abort_after > 0) && (seen == v.abort_after)) break;
            if (!bus.busy) break;
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 3000) check({v.name, "_run_timeout"}, 1, 0);

        if (v.abort_after > 0) begin
            check({v.name, "_pix_before_abort"}, seen, v.exp_pix);
            @(negedge clk);
            reset = 1'b0;
            @(negedge clk);
            check({v.name, "_rst_busy"}, int'(bus.busy), 0);
            check({v.name, "_rst_po"},   int'(bus.po), 0);
            check({v.name, "_rst_xo"},   int'(bus.xo), 0);
            check({v.name, "_rst_yo"},   int'(bus.yo), 0);
            check({v.name, "_rst_err"},  int'(bus.err), 0);
            reset = 1'b1;
            exp_q.delete();
            return;
        end

        check({v.name, "_pix_count"}, seen, v.exp_pix);
        check({v.name, "_queue_left"}, exp_q.size(), 0);
        check({v.name, "_err_cycles"}, errc, v.exp_err);
        check({v.name, "_busy_low"}, int'(bus.busy), 0);
        check({v.name, "_po_low"}, int'(bus.po), 0);
`ifdef TRAP_PIXCNT_EN
        check({v.name, "_pix_cnt"}, int'(bus.pix_cnt), v.exp_pix);
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{"rect",      2, 5, 4, 2, 3, 4, 0, 0,  9, 0};
        vecs[1] = '{"flat",      1, 7, 9, 3, 7, 5, 0, 0,  3, 0};
        vecs[2] = '{"slant",     0, 4, 8, 2, 0, 4, 0, 0, 29, 0};
        vecs[3] = '{"rect_bp",   2, 5, 4, 2, 3, 4, 1, 0,  9, 0};
        vecs[4] = '{"inverted",  1, 2, 3, 1, 6, 3, 0, 0,  0, 1};
        vecs[5] = '{"slant_rst", 0, 4, 8, 2, 0, 4, 0, 10, 10, 0};
        vecs[6] = '{"rect_again",2, 5, 4, 2, 3, 4, 0, 0,  9, 0};

        reset = 1'b0;
        bus.nt = 1'b0;
        bus.xi = 8'd0;
        bus.yi = 8'd0;
        bus.po_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_po",   int'(bus.po), 0);
        check("reset_xo",   int'(bus.xo), 0);
        check("reset_yo",   int'(bus.yo), 0);
        check("reset_err",  int'(bus.err), 0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
